// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types, constants and helpers for the mem_resp_sram responder.
// The LFSR constants are only consumed when MEM_RESP_STALL_EN is defined.
package mem_resp_pkg;

   // Responder FSM encoding; also visible on the debug state port.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_e;

   // Grant back-pressure LFSR: seed and Fibonacci taps 8,6,5,4 (bits 7,5,4,3).
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // True when addr falls inside [base, base + 4*depth). Computed on 33 bits
   // so a window ending at the top of the address space cannot wrap.
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth);
      logic [32:0] lo;
      logic [32:0] hi;
      logic [32:0] a;
      lo = {1'b0, base};
      hi = lo + ({1'b0, depth} << 2);
      a  = {1'b0, addr};
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/mem_resp_lfsr.sv
// mem_resp_lfsr: 8-bit Fibonacci LFSR with enable and asynchronous reset.
// Shifts left; the feedback bit is the XOR of the tapped bits.
module mem_resp_lfsr
   import mem_resp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   output logic [7:0] o_lfsr
);

   logic [7:0] r_lfsr;
   logic       w_fb;

   assign w_fb   = ^(r_lfsr & LFSR_TAPS);
   assign o_lfsr = r_lfsr;

   // Advance one step per enabled cycle; reseed on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr <= LFSR_SEED;
      end else if (i_en) begin
         r_lfsr <= {r_lfsr[6:0], w_fb};
      end
   end

endmodule

// File: rtl/mem_resp_sram.sv
// mem_resp_sram: word-addressed SRAM responder for the core/cache request
// protocol with a fixed response latency and one transaction outstanding.
// Optional feature macro: MEM_RESP_STALL_EN (pseudo-random grant back-pressure).
//
// Handshake: a request is accepted at the rising edge where req_i && gnt_o.
// gnt_o is combinational and only offered in IDLE. After acceptance the
// responder produces exactly one single-cycle rvalid_o pulse LATENCY cycles
// later, with rdata_o/error_o valid only while rvalid_o is high; no further
// grant is offered until that pulse has been issued.
module mem_resp_sram
   import mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
   parameter int unsigned LATENCY   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  be_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        error_o,
   output mem_state_e  dbg_state_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   mem_state_e  r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_cap_data;
   logic        r_cap_err;
   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic        r_error;
   logic [31:0] r_mem [DEPTH];

   logic          w_in_range;
   logic          w_accept;
   logic          w_stall;
   logic [31:0]   w_offset;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_cap_data;
   logic          w_cap_err;
   logic          w_unused_bits;

`ifdef MEM_RESP_STALL_EN
   logic [7:0] w_lfsr;

   mem_resp_lfsr u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .i_en   (1'b1),
      .o_lfsr (w_lfsr)
   );

   assign w_stall = w_lfsr[0];
`else
   assign w_stall = 1'b0;
`endif

   // Address decode: byte offset from the window base, low two bits dropped.
   assign w_in_range    = in_range(addr_i, BASE_ADDR, DEPTH);
   assign w_offset      = addr_i - BASE_ADDR;
   assign w_idx         = w_offset[AW+1:2];
   assign w_unused_bits = ^w_offset;

   assign gnt_o    = req_i && (r_state == IDLE) && !w_stall;
   assign w_accept = gnt_o;

   // Response payload as captured at the accept edge: data only for in-range reads.
   assign w_cap_err  = !w_in_range;
   assign w_cap_data = (w_in_range && !we_i) ? r_mem[w_idx] : 32'h0;

   assign rvalid_o    = r_rvalid;
   assign rdata_o     = r_rdata;
   assign error_o     = r_error;
   assign dbg_state_o = r_state;

   // Byte-lane write commits at the accept edge; the array is never reset.
   always_ff @(posedge clk) begin
      if (w_accept && we_i && w_in_range) begin
         for (int n = 0; n < 4; n++) begin
            if (be_i[n]) begin
               r_mem[w_idx][8*n +: 8] <= wdata_i[8*n +: 8];
            end
         end
      end
   end

   // Response FSM with registered rvalid/rdata/error outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_cap_data <= 32'h0;
         r_cap_err  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= 32'h0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_rvalid <= 1'b0;
               r_error  <= 1'b0;
               if (w_accept) begin
                  r_cap_data <= w_cap_data;
                  r_cap_err  <= w_cap_err;
                  if (LATENCY == 1) begin
                     r_state  <= RESP;
                     r_rvalid <= 1'b1;
                     r_rdata  <= w_cap_data;
                     r_error  <= w_cap_err;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= 4'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state  <= RESP;
                  r_rvalid <= 1'b1;
                  r_rdata  <= r_cap_data;
                  r_error  <= r_cap_err;
               end
            end
            RESP: begin
               r_state  <= IDLE;
               r_rvalid <= 1'b0;
               r_error  <= 1'b0;
            end
            default: begin
               r_state  <= IDLE;
               r_rvalid <= 1'b0;
               r_error  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_resp_sram.md
Name: mem_resp_sram

Overview:
- Memory-side responder for the core/cache request protocol: req/we/addr/wdata/be in; gnt/rvalid/rdata/error out.
- Backs a word-addressed SRAM array with a configurable response latency.
- Sits below the instruction/data caches as their backing store, both in FPGA builds and as a bench memory model.
- Holds one transaction outstanding at a time.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, >= 2.
- BASE_ADDR, 32'h0010_0000, byte address of word 0; DEPTH*4-aligned.
- LATENCY, 1, cycles from the grant edge to the rvalid cycle; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  1  request valid.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address; addr_i[1:0] ignored.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables; be_i[n] covers wdata_i[8n+7:8n].
- gnt_o  out  1  request accepted this cycle (combinational).
- rvalid_o  out  1  response valid, one-cycle pulse.
- rdata_o  out  32  read data; 0 for writes and errors.
- error_o  out  1  out-of-range access; qualified by rvalid_o.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: state IDLE, rvalid_o=0, error_o=0, rdata_o=0, latency counter 0, captured request registers 0.
- Reset does not clear the SRAM array.
- States: IDLE, WAIT, RESP.
- gnt_o = req_i && state==IDLE (see Optional Feature). No grant is given in WAIT or RESP.
- Handshake: a transaction is accepted at the rising edge where req_i && gnt_o.
  - Master may drop or change req_i freely before the grant.
  - After the grant, the master must not expect another grant until it has seen rvalid_o.
- In-range test: BASE_ADDR <= addr_i < BASE_ADDR + 4*DEPTH. Word index = (addr_i - BASE_ADDR) >> 2, width $clog2(DEPTH).
- At the accept edge:
  - In-range write: each byte lane with be_i[n]=1 is written; other lanes are unchanged. be_i=0 is a legal no-op write that still responds.
  - In-range read: the full word is captured into the response register.
  - Out of range: nothing is written; error flag is captured as 1 and response data as 0.
  - Write: response data is captured as 0.
- Transitions:
  - IDLE -> RESP on accept if LATENCY==1.
  - IDLE -> WAIT on accept if LATENCY>1; counter loads LATENCY-1.
  - WAIT: counter decrements; move to RESP when it reaches 1.
  - RESP -> IDLE after one cycle.
- Outputs in RESP: rvalid_o=1, with rdata_o and error_o taken from the captured registers.
- Outputs outside RESP: rvalid_o=0 and error_o=0. rdata_o holds its last value, but is only meaningful with rvalid_o.
- Timing:
  - Accept edge at cycle T → rvalid_o high in cycle T+LATENCY.
  - Next grant is possible in cycle T+LATENCY+1.
  - Peak throughput is one transaction per LATENCY+1 cycles.
- Read-after-write to the same address returns the merged new word; there is no hazard because the write commits at its accept edge.
- Reset mid-transaction: the pending response is dropped and no rvalid_o is issued. A write already committed at its accept edge stays in the array.
- Memory contents power up undefined. Simulation builds may preload the array via $readmemh from a file named by plusarg.

Optional Feature:
- Macro MEM_RESP_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - gnt_o = req_i && state==IDLE && !lfsr[0], giving pseudo-random grant back-pressure.
  - All other timing is relative to the actual accept edge.
- Undefined: no LFSR is instantiated and gnt_o follows the base rule.

Decomposition:
- Package mem_resp_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - LFSR seed and tap localparams;
  - function in_range(addr, base, depth).
- Sub-module mem_resp_lfsr: 8-bit LFSR with enable and async reset. It is only instantiated under MEM_RESP_STALL_EN.

Test Plan:
- LATENCY=1: write 32'hDEADBEEF be=4'hF to BASE_ADDR+8, then read it → gnt_o in the request cycle, rvalid_o the next cycle, rdata_o=32'hDEADBEEF, error_o=0.
- Byte merge: word holds 32'h11223344; write 32'hAABBCCDD be=4'b0101 → read returns 32'h11BB33DD.
- LATENCY=4, back-to-back req_i held high → each rvalid_o arrives exactly 4 cycles after its grant, grants spaced 5 cycles apart, and gnt_o stays 0 during WAIT/RESP.
- Out-of-range read at BASE_ADDR-4, and a write at BASE_ADDR+4*DEPTH → rvalid_o with error_o=1 and rdata_o=0; array word 0 and the last word are unchanged.
- reset asserted in WAIT after a write grant → no rvalid_o; after reset a read returns the written data and state is IDLE.
- MEM_RESP_STALL_EN, req_i held for 200 cycles → gnt_o low on cycles with lfsr[0]=1 (matching a reference LFSR model), and every grant is followed by exactly one rvalid_o.
